datapath_seq: RTL and testbench

Sequencer directly upstream of the lab 5 `datapath`, replacing switch-driven control with automatic control. It accepts one register-transfer command per handshake, such as `ADD R2, R0, R1, LSL#1`. It then drives the datapath control inputs through read, execute and writeback states in the correct order. It pulses `done` when the command has fully retired. It shares the datapath's clock, so every control value it presents is sampled by the datapath on the next rising edge.

---
 rtl/datapath_seq.sv | 176 +++++++++++++++++
 tb/tb_datapath_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_seq.sv
// Command sequencer driving the lab 5 datapath through read / execute / writeback states.
// Define DATAPATH_SEQ_SIGNEXT_EN to sign-extend cmd_imm onto datapath_in (default: zero-extend).
module datapath_seq #(
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_rn,
    input  logic [2:0]       cmd_rm,
    input  logic [1:0]       cmd_shift,
    input  logic [IMM_W-1:0] cmd_imm,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             vsel,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic             loadc,
    output logic             loads,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [15:0]      datapath_in,
    output logic             busy,
    output logic             done,
    output logic             err
);
    typedef enum logic [2:0] {
        S_IDLE, S_GETA, S_GETB, S_EXEC, S_WIMM, S_WRITE, S_DONE
    } state_t;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVN  = 3'b101;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d, rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
    logic [1:0]       shift_q, shift_d;
    logic [IMM_W-1:0] imm_q, imm_d;
    logic             accept;
    logic             ext_bit;

    assign accept    = cmd_valid && (state_q == S_IDLE);
    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rn_d    = rn_q;
        rm_d    = rm_q;
        shift_d = shift_q;
        imm_d   = imm_q;
        case (state_q)
            S_IDLE: if (accept) begin
                op_d    = cmd_op;
                rd_d    = cmd_rd;
                rn_d    = cmd_rn;
                rm_d    = cmd_rm;
                shift_d = cmd_shift;
                imm_d   = cmd_imm;
                case (cmd_op)
                    OP_MOVI:                 state_d = S_WIMM;
                    OP_ADD, OP_CMP, OP_AND:  state_d = S_GETA;
                    OP_MOV, OP_MVN:          state_d = S_GETB;
                    default:                 state_d = S_DONE;
                endcase
            end
            S_GETA:  state_d = S_GETB;
            S_GETB:  state_d = S_EXEC;
            S_EXEC:  state_d = (op_q == OP_CMP) ? S_DONE : S_WRITE;
            S_WIMM:  state_d = S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            shift_q <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rn_q    <= rn_d;
            rm_q    <= rm_d;
            shift_q <= shift_d;
            imm_q   <= imm_d;
        end
    end

    // Controls depend only on registered state and latched fields, never on cmd_* inputs.
    always_comb begin
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            S_GETA: begin
                readnum = rn_q;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = rm_q;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                shift = shift_q;
                loadc = 1'b1;
                asel  = (op_q == OP_MOV) || (op_q == OP_MVN);
                loads = (op_q == OP_CMP);
                case (op_q)
                    OP_CMP:  ALUop = 2'b01;
                    OP_AND:  ALUop = 2'b10;
                    OP_MVN:  ALUop = 2'b11;
                    default: ALUop = 2'b00;
                endcase
            end
            S_WIMM: begin
                writenum = rd_q;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            S_WRITE: begin
                writenum = rd_q;
                write    = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                err  = (op_q[2:1] == 2'b11);
            end
            default: ;
        endcase
    end

`ifdef DATAPATH_SEQ_SIGNEXT_EN
    assign ext_bit = imm_q[IMM_W-1];
`else
    assign ext_bit = 1'b0;
`endif

    // Per-bit generate avoids a zero-width replication when IMM_W is 16.
    for (genvar gi = 0; gi < 16; gi++) begin : g_ext
        if (gi < IMM_W) begin : g_imm
            assign datapath_in[gi] = imm_q[gi];
        end else begin : g_pad
            assign datapath_in[gi] = ext_bit;
        end
    end
endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: behavioural lab-5 datapath on the control outputs plus an architectural register model.
module tb_datapath_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op, cmd_rd, cmd_rn, cmd_rm;
    logic [1:0]  cmd_shift;
    logic [7:0]  cmd_imm;
    logic [2:0]  readnum, writenum;
    logic        write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    logic        busy, done, err;

    int n_vectors = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    datapath_seq #(.IMM_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
        .cmd_shift(cmd_shift), .cmd_imm(cmd_imm),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
        .loads(loads), .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural lab-5 datapath consuming the sequencer's controls.
    logic [15:0] rf [8];
    logic [15:0] a_r, b_r, c_r, ain, bin, alu;
    logic        z_r;

    always_comb begin
        case (shift)
            2'b01:   bin = b_r << 1;
            2'b10:   bin = b_r >> 1;
            2'b11:   bin = {b_r[15], b_r[15:1]};
            default: bin = b_r;
        endcase
        if (bsel) bin = 16'h0000;
        ain = asel ? 16'h0000 : a_r;
        case (ALUop)
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            2'b11:   alu = ~bin;
            default: alu = ain + bin;
        endcase
    end

    always @(posedge clk) begin
        if (write) rf[writenum] <= vsel ? datapath_in : c_r;
        if (loada) a_r <= rf[readnum];
        if (loadb) b_r <= rf[readnum];
        if (loadc) c_r <= alu;
        if (loads) z_r <= (alu == 16'h0000);
    end

    // Architectural reference: register contents and Z computed from the command semantics.
    logic [15:0] ref_regs [8];
    logic        ref_z;
    logic [17:0] cur_ctl;
    logic [17:0] snap [16];

    assign cur_ctl = {readnum, writenum, write, vsel, loada, loadb, asel, bsel,
                      loadc, loads, shift, ALUop};

    function automatic logic [17:0] ctl(input logic [2:0] rdn, input logic [2:0] wrn,
                                        input logic wr, input logic vs, input logic la,
                                        input logic lb, input logic as, input logic lc,
                                        input logic ls, input logic [1:0] sh, input logic [1:0] op);
        return {rdn, wrn, wr, vs, la, lb, as, 1'b0, lc, ls, sh, op};
    endfunction

    function automatic logic [15:0] ext(input logic [7:0] v);
`ifdef DATAPATH_SEQ_SIGNEXT_EN
        return {{8{v[7]}}, v};
`else
        return {8'h00, v};
`endif
    endfunction

    function automatic int latency(input logic [2:0] op);
        case (op)
            3'd0:          return 2;
            3'd1, 3'd5:    return 4;
            3'd3:          return 4;
            3'd2, 3'd4:    return 5;
            default:       return 1;
        endcase
    endfunction

    function automatic logic [15:0] shifted(input logic [15:0] v, input logic [1:0] sh);
        case (sh)
            2'b01:   return v << 1;
            2'b10:   return v >> 1;
            2'b11:   return $signed(v) >>> 1;
            default: return v;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check latency, pulses, handshake and architectural effect.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [1:0] sh, input logic [7:0] imm);
        int          done_k, nw, nl, k;
        logic        err_seen;
        logic [15:0] a, b, res;
        logic        writes;
        a      = ref_regs[rn];
        b      = shifted(ref_regs[rm], sh);
        writes = 1'b1;
        case (op)
            3'd0:    res = ext(imm);
            3'd1:    res = b;
            3'd2:    res = a + b;
            3'd4:    res = a & b;
            3'd5:    res = ~b;
            default: begin res = 16'h0000; writes = 1'b0; end
        endcase
        @(negedge clk);
        check("ready_before", cmd_ready, 1);
        cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_shift = sh; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        done_k = 0; nw = 0; nl = 0; err_seen = 1'b0; k = 0;
        while (done_k == 0 && k < 12) begin
            k++;
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            snap[k] = cur_ctl;
            nw += int'(write);
            nl += int'(loads);
            if (done) begin
                done_k   = k;
                err_seen = err;
            end
        end
        check("done_latency", done_k, latency(op));
        check("err_pulse", err_seen, (op[2:1] == 2'b11));
        check("write_count", nw, writes);
        check("loads_count", nl, (op == 3'd3));
        @(negedge clk);
        check("ready_after_done", {cmd_ready, busy}, 2'b10);
        if (writes) begin
            ref_regs[rd] = res;
            check("reg_result", rf[rd], res);
        end
        if (op == 3'd3) begin
            ref_z = ((a - b) == 16'h0000);
            check("z_flag", z_r, ref_z);
        end
    endtask

    initial begin
        logic [8:0] done_bits, err_bits, ready_bits;
        int         nw;
        reset = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rn = '0; cmd_rm = '0; cmd_shift = '0; cmd_imm = '0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
        ref_z = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_ctl", cur_ctl, 18'h0);
        check("reset_status", {cmd_ready, busy, done, err}, 4'b0000);
        check("reset_dpin", datapath_in, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", cmd_ready, 1);

        // MOVI rd=3, imm=0x85: WIMM at T+1, DONE at T+2.
        run_cmd(3'd0, 3'd3, 3'd0, 3'd0, 2'b00, 8'h85);
        check("movi_wimm_ctl", snap[1], ctl(3'd0, 3'd3, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        check("movi_dpin", datapath_in, ext(8'h85));

        run_cmd(3'd0, 3'd0, 3'd0, 3'd0, 2'b00, 8'd5);
        run_cmd(3'd0, 3'd1, 3'd0, 3'd0, 2'b00, 8'd3);
        for (int i = 2; i < 8; i++)
            run_cmd(3'd0, 3'(i), 3'd0, 3'd0, 2'b00, 8'($urandom_range(0, 255)));
        run_cmd(3'd0, 3'd7, 3'd0, 3'd0, 2'b00, 8'd9);
        run_cmd(3'd0, 3'd4, 3'd0, 3'd0, 2'b00, 8'd9);

        // ADD R2, R0, R1, LSL#1 with R0=5, R1=3 -> 11.
        run_cmd(3'd2, 3'd2, 3'd0, 3'd1, 2'b01, 8'd0);
        check("add_geta", snap[1], ctl(3'd0, 3'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00));
        check("add_getb", snap[2], ctl(3'd1, 3'd0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00));
        check("add_exec", snap[3], ctl(3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00));
        check("add_write", snap[4], ctl(3'd0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        check("add_done", snap[5], 18'h0);
        check("add_r2", rf[2], 16'd11);

        // CMP R4, R4: equal -> Z=1.
        run_cmd(3'd3, 3'd0, 3'd4, 3'd4, 2'b00, 8'd0);
        check("cmp_exec", snap[3], ctl(3'd0, 3'd0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b01));
        check("cmp_z", z_r, 1);

        // MVN R5, R1 back-to-back with an illegal op, cmd_valid held high.
        @(negedge clk);
        cmd_op = 3'd5; cmd_rd = 3'd5; cmd_rn = 3'd0; cmd_rm = 3'd1; cmd_shift = 2'b00;
        cmd_valid = 1'b1;
        @(posedge clk);
        done_bits = '0; err_bits = '0; ready_bits = '0; nw = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) cmd_op = 3'd6;
            snap[k]       = cur_ctl;
            done_bits[k]  = done;
            err_bits[k]   = err;
            ready_bits[k] = cmd_ready;
            nw += int'(write);
            if (k == 6) cmd_valid = 1'b0;
        end
        ref_regs[5] = ~ref_regs[1];
        check("mvn_exec", snap[2], ctl(3'd0, 3'd0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b11));
        check("b2b_done", done_bits, 9'b001010000);
        check("b2b_err", err_bits, 9'b001000000);
        check("b2b_ready", ready_bits, 9'b110100000);
        check("b2b_writes", nw, 1);
        check("mvn_r5", rf[5], ref_regs[5]);

        // Reset asserted during EXEC of an ADD: abandoned, no writeback.
        @(negedge clk);
        cmd_op = 3'd2; cmd_rd = 3'd6; cmd_rn = 3'd0; cmd_rm = 3'd1; cmd_shift = 2'b00;
        cmd_valid = 1'b1;
        @(posedge clk);
        nw = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            nw += int'(write);
        end
        check("pre_reset_exec", {loadc, busy}, 2'b11);
        reset = 1'b1;
        #1;
        check("midreset_ctl", cur_ctl, 18'h0);
        check("midreset_status", {cmd_ready, busy, done, err, datapath_in}, 20'h0);
        @(negedge clk);
        nw += int'(write);
        reset = 1'b0;
        #1;
        check("ready_after_midreset", {cmd_ready, busy}, 2'b10);
        @(negedge clk);
        nw += int'(write);
        check("midreset_writes", nw, 0);
        check("midreset_r6", rf[6], ref_regs[6]);

        for (int i = 0; i < 40; i++)
            run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
